// File: rtl/wave_seq_ctrl.sv
// Waveform playback sequencer: steps sample addresses at a divided rate
// for a programmed number of waveform periods, or continuously.
module wave_seq_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Trigger,
    input  logic               Stop,
    input  logic [DIV_W-1:0]   Div,
    input  logic [ADDR_W-1:0]  Length,
    input  logic [BURST_W-1:0] Burst_Count,
    output logic [ADDR_W-1:0]  Addr,
    output logic               Sample_EN,
    output logic               Reset_BAC,
    output logic               Busy,
    output logic               Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]   div_s_q, div_s_d;
    logic [ADDR_W-1:0]  len_s_q, len_s_d;
    logic [BURST_W-1:0] burst_s_q, burst_s_d;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] period_q, period_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               sample_en_q, sample_en_d;
    logic               reset_bac_q, reset_bac_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               start_req;
    logic               run_hit;
    logic               period_end;
    logic               burst_end;
    logic [BURST_W:0]   period_inc;

    assign start_req  = Trigger && !Stop;
    assign run_hit    = (state_q == S_RUN) && (div_q == div_s_q);
    assign period_end = run_hit && (addr_q == len_s_q);
    assign period_inc = {1'b0, period_q} + (BURST_W + 1)'(1);
    assign burst_end  = period_end && (burst_s_q != '0)
                        && (period_inc == {1'b0, burst_s_q});

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = Stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (Stop) begin
                    state_d = S_IDLE;
                end else if (burst_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so every port is a flop.
    always_comb begin
        div_s_d     = div_s_q;
        len_s_d     = len_s_q;
        burst_s_d   = burst_s_q;
        div_d       = '0;
        period_d    = period_q;
        addr_d      = addr_q;
        sample_en_d = 1'b0;
        reset_bac_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        if (state_q == S_IDLE && start_req) begin
            div_s_d   = Div;
            len_s_d   = Length;
            burst_s_d = Burst_Count;
        end

        unique case (state_d)
            S_START: begin
                addr_d      = '0;
                period_d    = '0;
                reset_bac_d = 1'b0;
                busy_d      = 1'b1;
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (state_q == S_RUN && !run_hit) begin
                    div_d = div_q + DIV_W'(1);
                end
                if (period_end) begin
                    addr_d = '0;
                    if (period_q != '1) begin
                        period_d = period_inc[BURST_W-1:0];
                    end
                end else if (run_hit) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                sample_en_d = (div_d == div_s_d);
            end
            S_DONE: begin
                addr_d = '0;
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            div_s_q     <= '0;
            len_s_q     <= '0;
            burst_s_q   <= '0;
            div_q       <= '0;
            period_q    <= '0;
            addr_q      <= '0;
            sample_en_q <= 1'b0;
            reset_bac_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            div_s_q     <= div_s_d;
            len_s_q     <= len_s_d;
            burst_s_q   <= burst_s_d;
            div_q       <= div_d;
            period_q    <= period_d;
            addr_q      <= addr_d;
            sample_en_q <= sample_en_d;
            reset_bac_q <= reset_bac_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Addr      = addr_q;
    assign Sample_EN = sample_en_q;
    assign Reset_BAC = reset_bac_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule
